// File: rtl/comparador_filtro.sv
// Debounces the one-hot igual/mayor/menor result of a signed comparator into a stable
// registered decision, with saturating per-class counters and an illegal-sample pulse.
module comparador_filtro #(
    parameter int N_ESTABLE = 4,
    parameter int ANCHO_CNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valido,
    input  logic                 igual,
    input  logic                 mayor,
    input  logic                 menor,
    input  logic                 limpiar,
    output logic [1:0]           estado,
    output logic                 cambio,
    output logic                 error,
    output logic [ANCHO_CNT-1:0] cnt_igual,
    output logic [ANCHO_CNT-1:0] cnt_mayor,
    output logic [ANCHO_CNT-1:0] cnt_menor
);

    localparam int RUN_W = $clog2(N_ESTABLE + 1);
    localparam logic [RUN_W-1:0]     RUN_MAX = RUN_W'(N_ESTABLE);
    localparam logic [ANCHO_CNT-1:0] CNT_MAX = '1;

    logic [1:0]           r_estado;
    logic                 r_cambio;
    logic                 r_error;
    logic [1:0]           r_cand;
    logic [RUN_W-1:0]     r_run;
    logic [ANCHO_CNT-1:0] r_cnt_igual;
    logic [ANCHO_CNT-1:0] r_cnt_mayor;
    logic [ANCHO_CNT-1:0] r_cnt_menor;

    logic [1:0]           w_num_flags;
    logic                 w_legal;
    logic                 w_acepta_legal;
    logic [1:0]           w_muestra;
    logic [RUN_W-1:0]     w_run_next;
    logic [ANCHO_CNT-1:0] w_base_igual;
    logic [ANCHO_CNT-1:0] w_base_mayor;
    logic [ANCHO_CNT-1:0] w_base_menor;
    logic [ANCHO_CNT-1:0] w_cnt_igual_next;
    logic [ANCHO_CNT-1:0] w_cnt_mayor_next;
    logic [ANCHO_CNT-1:0] w_cnt_menor_next;

    assign w_num_flags    = 2'(igual) + 2'(mayor) + 2'(menor);
    assign w_legal        = (w_num_flags == 2'd1);
    assign w_acepta_legal = valido && w_legal;

    always_comb begin
        w_muestra = 2'b00;
        if (igual)      w_muestra = 2'b11;
        else if (mayor) w_muestra = 2'b10;
        else if (menor) w_muestra = 2'b01;
    end

    // r_cand is 00 whenever no run is in progress, so a legal sample never matches it then.
    always_comb begin
        w_run_next = RUN_W'(1);
        if (w_muestra == r_cand) begin
            if (r_run == RUN_MAX) w_run_next = RUN_MAX;
            else                  w_run_next = r_run + RUN_W'(1);
        end
    end

    // limpiar zeroes the base first so a coincident legal sample lands at exactly 1.
    always_comb begin
        w_base_igual     = limpiar ? '0 : r_cnt_igual;
        w_base_mayor     = limpiar ? '0 : r_cnt_mayor;
        w_base_menor     = limpiar ? '0 : r_cnt_menor;
        w_cnt_igual_next = w_base_igual;
        w_cnt_mayor_next = w_base_mayor;
        w_cnt_menor_next = w_base_menor;
        if (w_acepta_legal && w_muestra == 2'b11 && w_base_igual != CNT_MAX)
            w_cnt_igual_next = w_base_igual + ANCHO_CNT'(1);
        if (w_acepta_legal && w_muestra == 2'b10 && w_base_mayor != CNT_MAX)
            w_cnt_mayor_next = w_base_mayor + ANCHO_CNT'(1);
        if (w_acepta_legal && w_muestra == 2'b01 && w_base_menor != CNT_MAX)
            w_cnt_menor_next = w_base_menor + ANCHO_CNT'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado    <= 2'b00;
            r_cambio    <= 1'b0;
            r_error     <= 1'b0;
            r_cand      <= 2'b00;
            r_run       <= '0;
            r_cnt_igual <= '0;
            r_cnt_mayor <= '0;
            r_cnt_menor <= '0;
        end else begin
            r_cambio    <= 1'b0;
            r_error     <= 1'b0;
            r_cnt_igual <= w_cnt_igual_next;
            r_cnt_mayor <= w_cnt_mayor_next;
            r_cnt_menor <= w_cnt_menor_next;
            if (valido) begin
                if (w_legal) begin
                    r_cand <= w_muestra;
                    r_run  <= w_run_next;
                    if (w_run_next == RUN_MAX && w_muestra != r_estado) begin
                        r_estado <= w_muestra;
                        r_cambio <= 1'b1;
                    end
                end else begin
                    r_error <= 1'b1;
                    r_cand  <= 2'b00;
                    r_run   <= '0;
                end
            end
        end
    end

    assign estado    = r_estado;
    assign cambio    = r_cambio;
    assign error     = r_error;
    assign cnt_igual = r_cnt_igual;
    assign cnt_mayor = r_cnt_mayor;
    assign cnt_menor = r_cnt_menor;

endmodule

// File: doc/comparador_filtro.md
Name: comparador_filtro

Overview:
Downstream consumer of the 8-bit signed comparator's one-hot result flags (igual/mayor/menor). Accepts one flag triple per valid cycle and debounces it into a stable registered decision. A decision changes only after N_ESTABLE consecutive identical legal samples. Also keeps saturating per-class sample counters and flags illegal (non-one-hot) inputs.

Parameters:
N_ESTABLE, 4, consecutive identical legal samples needed to change estado; legal range >= 1
ANCHO_CNT, 8, width of each per-class sample counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
valido  input  1  igual/mayor/menor carry a sample this cycle
igual  input  1  comparator equal flag
mayor  input  1  comparator greater flag (signed a > b)
menor  input  1  comparator less flag (signed a < b)
limpiar  input  1  clear the three counters; estado and debounce state untouched
estado  output  2  filtered decision: 00 undetermined, 01 menor, 10 mayor, 11 igual
cambio  output  1  one-cycle pulse when estado changes
error  output  1  one-cycle pulse when an illegal sample is accepted
cnt_igual  output  ANCHO_CNT  count of legal igual samples, saturating
cnt_mayor  output  ANCHO_CNT  count of legal mayor samples, saturating
cnt_menor  output  ANCHO_CNT  count of legal menor samples, saturating

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst has priority over all other inputs.
- Reset values: estado=00, cambio=0, error=0, all counters 0. Internal candidate cand=00, run counter run=0.
- Sample accepted on a rising edge with valido=1.
- A sample is legal iff exactly one of igual/mayor/menor is 1. It is encoded as 01 (menor), 10 (mayor) or 11 (igual).
- Illegal sample (zero flags, or two or more flags):
  - error=1 for the cycle after the accepting edge.
  - cand=00, run=0.
  - Counters and estado unchanged.
- Legal sample s:
  - If s==cand: run = min(run+1, N_ESTABLE).
  - Otherwise: cand=s, run=1.
- Decision update: on the same edge that brings run to N_ESTABLE, if s != estado, then estado<=s and cambio=1 for one cycle.
  - Latency: estado is visible the cycle after the Nth consecutive sample is accepted.
  - Further identical samples (run held at N_ESTABLE) cause no pulse.
- N_ESTABLE=1: every legal sample that differs from estado updates it immediately.
- estado never returns to 00 except through rst.
- valido=0: all state held, cambio=0, error=0.
  - Gaps in valido do not break a run; consecutive means consecutive accepted samples.
- Counters: each legal accepted sample increments the matching counter. Counters saturate at 2^ANCHO_CNT-1 and never wrap. Illegal samples are not counted.
- limpiar=1 clears all counters to 0. If limpiar and a legal sample arrive on the same edge, the matching counter becomes 1 and the others become 0.
- Reset mid-run: the run is discarded. The next sample starts at run=1.
- Run counter width: enough bits to hold N_ESTABLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Assert rst 2 cycles with random flags and valido=1 -> estado=00, cambio=0, error=0, all counters 0.
2. N_ESTABLE=4: 4 consecutive mayor samples (one per cycle) -> estado=10 and cambio=1 exactly one cycle after the 4th edge; cnt_mayor=4. A 5th mayor sample -> no cambio, cnt_mayor=5.
3. Glitch rejection: from estado=10, send menor x3, igual x1, menor x4 -> estado stays 10 until the 4th trailing menor, then estado=01 with a single cambio pulse; cnt_menor=7, cnt_igual=1.
4. Illegal input: mayor=menor=1 with valido=1 in the middle of a 3-sample igual run -> error pulse, counters unchanged, run cleared. 4 further igual samples are needed before estado=11.
5. valido gaps and reset mid-run:
   - igual samples separated by 1-3 idle cycles -> still count as consecutive; estado=11 after the 4th.
   - rst after 2 samples of a run -> run discarded; 4 fresh samples required.
6. ANCHO_CNT=4: 20 igual samples -> cnt_igual saturates at 15. limpiar together with a mayor sample -> cnt_mayor=1, cnt_igual=0, cnt_menor=0, estado unchanged.
